sprite_write_scheduler: RTL

Schedules writes into the sprite attribute register file of the sprite pipeline's S1 stage. It arbitrates between two requesters: the host port and the animation engine. Accepted writes are buffered in a small FIFO and issued on the spriter's `address`/`rwenable`/`datain` port only during vertical blanking, so sprite attributes never change mid-frame. The block sits between the requesters and the spriter, in the `clk_25` domain.

---
 rtl/sprite_write_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sprite_write_scheduler.sv
// Sprite attribute write scheduler: arbitrates host/animation writes
// into a FIFO and issues them to the spriter only during vertical blank.
module sprite_write_scheduler #(
  parameter int DEPTH    = 4,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk_25,
  input  logic        n_reset,
  input  logic [9:0]  row,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [18:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [18:0] req1_data,
  output logic        req1_ready,
  output logic [4:0]  address,
  output logic [18:0] datain,
  output logic        rwenable,
  output logic [4:0]  pending,
  output logic        drained
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    BLANK_IDLE
  } state_t;

  state_t        state;
  logic          in_blank;
  logic          last_grant;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [23:0]   mem [DEPTH];

  logic          gnt0;
  logic          gnt1;
  logic          push;
  logic          pop;
  logic [23:0]   push_word;
  logic [23:0]   head_word;

  // last_grant=1 means req1 won last, so req0 has priority next
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (pending < 5'(DEPTH)) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign push       = gnt0 | gnt1;
  assign push_word  = gnt0 ? {req0_addr, req0_data}
                           : {req1_addr, req1_data};
  assign head_word  = mem[head];
  assign pop        = (state == DRAIN) && in_blank
                      && (pending != 5'd0);

  always_ff @(posedge clk_25) begin
    if (push) mem[tail] <= push_word;
  end

  always_ff @(posedge clk_25 or negedge n_reset) begin
    if (!n_reset) begin
      in_blank   <= 1'b0;
      last_grant <= 1'b1;
      head       <= '0;
      tail       <= '0;
      pending    <= '0;
    end else begin
      in_blank <= (row >= 10'(V_ACTIVE));
      if (push) begin
        last_grant <= gnt1;
        tail       <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   pending <= pending + 5'd1;
        2'b01:   pending <= pending - 5'd1;
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk_25 or negedge n_reset) begin
    if (!n_reset) begin
      state    <= ACTIVE;
      address  <= '0;
      datain   <= '0;
      rwenable <= 1'b0;
      drained  <= 1'b0;
    end else begin
      rwenable <= 1'b0;
      drained  <= 1'b0;
      unique case (state)
        ACTIVE: begin
          if (in_blank) state <= DRAIN;
        end
        DRAIN: begin
          if (!in_blank) begin
            state <= ACTIVE;
          end else if (pending != 5'd0) begin
            rwenable <= 1'b1;
            address  <= head_word[23:19];
            datain   <= head_word[18:0];
            if (pending == 5'd1 && !push) begin
              drained <= 1'b1;
              state   <= BLANK_IDLE;
            end
          end else if (!push) begin
            // a push into an empty FIFO keeps us draining for next cycle
            state <= BLANK_IDLE;
          end
        end
        BLANK_IDLE: begin
          if (!in_blank) state <= ACTIVE;
          else if (pending != 5'd0) state <= DRAIN;
        end
        default: state <= ACTIVE;
      endcase
    end
  end

endmodule
